// File: rtl/prbs_pkg.sv
// prbs_pkg: shared FSM encoding and the LFSR step function used by the PRBS
// generator, the prbs_checker and their testbench models.
`default_nettype none

package prbs_pkg;

    localparam int PRBS_MAX_W = 64;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } prbs_state_e;

    localparam logic [1:0] ST_HUNT   = HUNT;
    localparam logic [1:0] ST_VERIFY = VERIFY;
    localparam logic [1:0] ST_LOCKED = LOCKED;

    // Galois-style update for an nbits-wide register held in the low bits of a
    // 64-bit container; bits above nbits are always returned as zero.
    function automatic logic [PRBS_MAX_W-1:0] prbs_step(
        input logic [PRBS_MAX_W-1:0] w,
        input logic [PRBS_MAX_W-1:0] taps,
        input int unsigned           nbits,
        input logic                  invert
    );
        logic [PRBS_MAX_W-1:0] mask;
        logic [PRBS_MAX_W-1:0] top;
        logic                  fb;
        mask = (nbits >= 64) ? {PRBS_MAX_W{1'b1}}
                             : ((64'd1 << nbits) - 64'd1);
        top  = 64'd1 << (nbits - 1);
        fb   = (|(w & top)) ^ invert;
        return ((w << 1) & mask) ^ (fb ? (taps & mask) : {PRBS_MAX_W{1'b0}});
    endfunction

endpackage

`default_nettype wire

// File: rtl/prbs_popcount.sv
// prbs_popcount: combinational population count of an NBITS-wide vector.
`default_nettype none

module prbs_popcount #(
    parameter int NBITS = 8,
    parameter int OUT_W = $clog2(NBITS + 1)
) (
    input  logic [NBITS-1:0] bits,
    output logic [OUT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < NBITS; i++) begin
            count = count + OUT_W'(bits[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/prbs_checker.sv
// prbs_checker: seeds a local LFSR replica from the received stream, acquires
// lock, then counts pattern errors while flywheeling. Option macro: PRBS_CHECKER_BITERR_EN.
`default_nettype none

module prbs_checker
    import prbs_pkg::*;
#(
    parameter         TAPS       = 8'hB8,
    parameter bit     INVERT     = 1'b0,
    parameter int     LOCK_COUNT = 4,
    parameter int     LOSS_COUNT = 3,
    parameter int     CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid,
    input  logic [$bits(TAPS)-1:0]   data_in,
    input  logic                     clear,
    output logic                     locked,
    output logic                     err,
    output logic                     sync_lost,
    output logic [CNT_W-1:0]         err_count
);

    localparam int NBITS = $bits(TAPS);
    localparam int MR_W  = $clog2(LOCK_COUNT + 1);
    localparam int LR_W  = $clog2(LOSS_COUNT + 1);

    localparam logic [PRBS_MAX_W-1:0] TAPS_EXT = PRBS_MAX_W'(TAPS);

    logic [1:0]       state;
    logic [NBITS-1:0] expected;
    logic [MR_W-1:0]  match_run;
    logic [LR_W-1:0]  miss_run;

    function automatic logic [NBITS-1:0] step(input logic [NBITS-1:0] w);
        return NBITS'(prbs_step(PRBS_MAX_W'(w), TAPS_EXT, NBITS, INVERT));
    endfunction

    logic [NBITS-1:0] in_step;
    logic [NBITS-1:0] exp_step;
    logic             mismatch;
    logic             lockup_word;
    logic             count_err;
    logic             match_done;
    logic             miss_done;

    always_comb begin
        in_step     = step(data_in);
        exp_step    = step(expected);
        mismatch    = (data_in != expected);
        lockup_word = (in_step == data_in);
        count_err   = valid && (state == ST_LOCKED) && mismatch;
        match_done  = ((int'(match_run) + 1) == LOCK_COUNT);
        miss_done   = ((int'(miss_run) + 1) == LOSS_COUNT);
    end

    // Error weight: whole words by default, individual bits when enabled.
`ifdef PRBS_CHECKER_BITERR_EN
    localparam int WT_W = $clog2(NBITS + 1);
    logic [WT_W-1:0] weight;
    logic [NBITS-1:0] diff_bits;

    assign diff_bits = data_in ^ expected;

    prbs_popcount #(
        .NBITS (NBITS),
        .OUT_W (WT_W)
    ) u_popcount (
        .bits  (diff_bits),
        .count (weight)
    );
`else
    localparam int WT_W = 1;
    logic [WT_W-1:0] weight;

    assign weight = 1'b1;
`endif

    localparam int SUM_W = ((CNT_W > WT_W) ? CNT_W : WT_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX =
        {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] count_base;
    logic [SUM_W-1:0] count_sum;
    logic [CNT_W-1:0] count_next;

    // Clear zeroes the base first so a same-cycle error still lands.
    always_comb begin
        count_base = clear ? '0 : err_count;
        count_sum  = SUM_W'(count_base) + SUM_W'(weight);
        count_next = count_base;
        if (count_err) begin
            count_next = (count_sum > CNT_MAX) ? {CNT_W{1'b1}}
                                               : count_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_HUNT;
            expected  <= '0;
            match_run <= '0;
            miss_run  <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            sync_lost <= 1'b0;
            err_count <= '0;
        end else begin
            err       <= count_err;
            sync_lost <= 1'b0;
            err_count <= count_next;
            if (valid) begin
                case (state)
                    ST_HUNT: begin
                        if (!lockup_word) begin
                            expected  <= in_step;
                            match_run <= '0;
                            state     <= ST_VERIFY;
                        end
                    end
                    ST_VERIFY: begin
                        if (!mismatch) begin
                            expected <= exp_step;
                            if (match_done) begin
                                match_run <= '0;
                                miss_run  <= '0;
                                locked    <= 1'b1;
                                state     <= ST_LOCKED;
                            end else begin
                                match_run <= match_run + 1'b1;
                            end
                        end else begin
                            expected  <= in_step;
                            match_run <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        // Flywheel: the replica never reseeds once locked.
                        expected <= exp_step;
                        if (mismatch) begin
                            if (miss_done) begin
                                miss_run  <= '0;
                                locked    <= 1'b0;
                                sync_lost <= 1'b1;
                                state     <= ST_HUNT;
                            end else begin
                                miss_run <= miss_run + 1'b1;
                            end
                        end else begin
                            miss_run <= '0;
                        end
                    end
                    default: begin
                        state  <= ST_HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed self-checking bench for prbs_checker (TAPS 8'hB8,
// LOCK_COUNT 4, LOSS_COUNT 3, CNT_W 4).
`default_nettype none

module tb_prbs_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic [7:0] data_in;
    logic       clear;
    logic       locked;
    logic       err;
    logic       sync_lost;
    logic [3:0] err_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] g;
    int         pulses;

`ifdef PRBS_CHECKER_BITERR_EN
    localparam int W3 = 3;
`else
    localparam int W3 = 1;
`endif

    always #5 clk = ~clk;

    prbs_checker #(
        .TAPS       (8'hB8),
        .INVERT     (1'b0),
        .LOCK_COUNT (4),
        .LOSS_COUNT (3),
        .CNT_W      (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .data_in   (data_in),
        .clear     (clear),
        .locked    (locked),
        .err       (err),
        .sync_lost (sync_lost),
        .err_count (err_count)
    );

    function automatic logic [7:0] tb_step(input logic [7:0] w);
        return {w[6:0], 1'b0} ^ (w[7] ? 8'hB8 : 8'h00);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic c);
        @(negedge clk);
        valid   = v;
        data_in = d;
        clear   = c;
        @(posedge clk);
        #1;
        valid = 1'b0;
        clear = 1'b0;
        if (err) pulses++;
    endtask

    task automatic gen_word(input logic [7:0] flip, input logic c);
        drive(1'b1, g ^ flip, c);
        g = tb_step(g);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        valid   = 1'b1;
        clear   = 1'b1;
        data_in = g;
        @(posedge clk);
        #1;
        reset = 1'b0;
        valid = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        valid   = 1'b0;
        clear   = 1'b0;
        data_in = 8'h00;
        g       = 8'hFF;
        pulses  = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_locked", 32'(locked), 0);
        check("rst_err", 32'(err), 0);
        check("rst_sync_lost", 32'(sync_lost), 0);
        check("rst_count", 32'(err_count), 0);

        // First words of the seed-FF sequence, computed by hand.
        check("seq_1", 32'(tb_step(8'hFF)), 32'h46);
        check("seq_3", 32'(tb_step(tb_step(8'h46))), 32'hA0);

        // Lock acquisition: seed + 4 matches.
        g = 8'hFF;
        for (int i = 0; i < 4; i++) gen_word(8'h00, 1'b0);
        check("lock_not_yet", 32'(locked), 0);
        gen_word(8'h00, 1'b0);
        check("lock_after_5", 32'(locked), 1);

        pulses = 0;
        for (int i = 0; i < 1000; i++) gen_word(8'h00, 1'b0);
        check("clean_pulses", 32'(pulses), 0);
        check("clean_count", 32'(err_count), 0);
        check("clean_locked", 32'(locked), 1);

        // Single corrupted word: counted, lock held, flywheel continues.
        gen_word(8'h01, 1'b0);
        check("one_err", 32'(err), 1);
        check("one_count", 32'(err_count), 1);
        check("one_locked", 32'(locked), 1);
        pulses = 0;
        for (int i = 0; i < 5; i++) gen_word(8'h00, 1'b0);
        check("fly_pulses", 32'(pulses), 0);
        check("fly_count", 32'(err_count), 1);

        // Three consecutive corrupted words drop lock on the third.
        gen_word(8'h10, 1'b0);
        check("loss1_err", 32'(err), 1);
        check("loss1_locked", 32'(locked), 1);
        gen_word(8'h10, 1'b0);
        check("loss2_sync", 32'(sync_lost), 0);
        check("loss2_locked", 32'(locked), 1);
        gen_word(8'h10, 1'b0);
        check("loss3_err", 32'(err), 1);
        check("loss3_sync", 32'(sync_lost), 1);
        check("loss3_locked", 32'(locked), 0);
        check("loss3_count", 32'(err_count), 4);
        gen_word(8'h00, 1'b0);
        check("relock_sync_pulse", 32'(sync_lost), 0);
        check("relock_no_err", 32'(err), 0);
        for (int i = 0; i < 3; i++) gen_word(8'h00, 1'b0);
        check("relock_not_yet", 32'(locked), 0);
        gen_word(8'h00, 1'b0);
        check("relock_after_5", 32'(locked), 1);

        // Lockup word in HUNT, then a break during VERIFY.
        do_reset();
        check("rst2_count", 32'(err_count), 0);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h00, 1'b0);
        check("hunt_zero_locked", 32'(locked), 0);
        g = 8'h3C;
        for (int i = 0; i < 3; i++) gen_word(8'h00, 1'b0);
        begin
            logic [7:0] brk;
            brk = g ^ 8'h80;
            drive(1'b1, brk, 1'b0);
            g = tb_step(brk);
        end
        check("verify_break_locked", 32'(locked), 0);
        for (int i = 0; i < 3; i++) gen_word(8'h00, 1'b0);
        check("reseed_3_locked", 32'(locked), 0);
        gen_word(8'h00, 1'b0);
        check("reseed_4_locked", 32'(locked), 1);
        check("verify_no_count", 32'(err_count), 0);

        // Saturation, then clear against a coincident error.
        for (int i = 0; i < 20; i++) begin
            gen_word(8'h01, 1'b0);
            gen_word(8'h00, 1'b0);
        end
        check("sat_count", 32'(err_count), 15);
        check("sat_locked", 32'(locked), 1);
        gen_word(8'h07, 1'b1);
        check("clear_with_err", 32'(err_count), 32'(W3));
        gen_word(8'h00, 1'b1);
        check("clear_plain", 32'(err_count), 0);

        // Gapped valid: idle cycles carry junk that must be ignored.
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 1) gen_word(8'h00, 1'b0);
            else drive(1'b0, 8'($urandom), 1'b0);
        end
        check("gap_pulses", 32'(pulses), 0);
        check("gap_locked", 32'(locked), 1);
        check("gap_count", 32'(err_count), 0);

        gen_word(8'h01, 1'b0);
        do_reset();
        check("rst3_locked", 32'(locked), 0);
        check("rst3_err", 32'(err), 0);
        check("rst3_sync_lost", 32'(sync_lost), 0);
        check("rst3_count", 32'(err_count), 0);
        for (int i = 0; i < 4; i++) gen_word(8'h00, 1'b0);
        check("rst3_hunt_4", 32'(locked), 0);
        gen_word(8'h00, 1'b0);
        check("rst3_hunt_5", 32'(locked), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prbs_checker.md
# prbs_checker

Receive-side companion to the LFSR pattern generator. Takes NBITS-wide LFSR words arriving over a link (e.g. a test pattern carried on an HDMI pixel channel), seeds a local replica of the generator from the stream, acquires lock, then counts pattern errors while flywheeling through corruption. Sits at the sink end of link bring-up and BER test paths.

## Interface
- TAPS, 8'hB8, feedback tap bitmask; NBITS = $bits(TAPS)
- INVERT, 0, invert feedback bit; must match the generator
- LOCK_COUNT, 4, consecutive matches needed to declare lock (≥1)
- LOSS_COUNT, 3, consecutive mismatches in LOCKED that drop lock (≥1)
- CNT_W, 16, error counter width
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- valid  in  1  data_in is a new word this cycle
- data_in  in  NBITS  received LFSR word
- clear  in  1  synchronous clear of err_count
- locked  out  1  pattern lock
- err  out  1  one-cycle pulse: mismatch counted this sample
- sync_lost  out  1  one-cycle pulse: LOCKED→HUNT
- err_count  out  CNT_W  saturating error count

## Operation
- step(w) = {w[NBITS-2:0],1'b0} ^ ((w[NBITS-1]^INVERT) ? TAPS : 0), identical to the generator's enabled-shift update.
- Nothing happens on cycles with valid=0; all state holds.
- HUNT: on valid, if step(data_in)==data_in (lockup word) stay in HUNT; else expected<=step(data_in), match_run<=0, go VERIFY.
- VERIFY: on valid, data_in==expected → expected<=step(expected), match_run++; when match_run+1==LOCK_COUNT go LOCKED. Mismatch → reseed: expected<=step(data_in), match_run<=0, stay VERIFY. No errors counted outside LOCKED.
- LOCKED: on valid, expected<=step(expected) always (flywheel, never reseed). Mismatch → err pulse, err_count += weight, miss_run++; when miss_run+1==LOSS_COUNT go HUNT and pulse sync_lost. Match → miss_run<=0.
- weight: 1 per mismatched word (default); see Configuration.
- err_count saturates at 2^CNT_W−1; never wraps.
- clear: err_count<=weight if an error is counted the same cycle, else 0. State machine unaffected.
- reset overrides clear and valid at any point, including mid-VERIFY/LOCKED.

## Timing
- All outputs registered; response to a valid sample appears the cycle after it is presented.
- Reset values: state HUNT, locked=0, err=0, sync_lost=0, err_count=0, expected=0, match_run=0, miss_run=0.
- Lock latency with a clean stream: 1 seed word + LOCK_COUNT matching words; locked rises the cycle after the last of them.
- locked falls in the same cycle that sync_lost pulses.
- err and sync_lost are high for exactly one cycle per event; both may be high together.
- Back-to-back valid every cycle is supported with no bubbles.

## Configuration
- PRBS_CHECKER_BITERR_EN defined: weight = popcount(data_in ^ expected) (bit error count); saturation still applies, adding in one step.
- Undefined: weight = 1 per mismatched word; no popcount logic synthesised.
- Lock/loss decisions are word-based in both builds.

## Structure
- prbs_pkg: state enum (HUNT, VERIFY, LOCKED) and the step() function, shared with the generator's testbench model.
- Sub-module prbs_popcount (NBITS in, $clog2(NBITS+1) out, combinational), instantiated only under PRBS_CHECKER_BITERR_EN.

## Test plan
- TAPS=8'hB8, generator seeded 8'hFF, valid every cycle -> locked rises after 5th word, err_count=0 over 1000 words.
- Locked; flip one bit of one word -> err pulse once, err_count=1 (BITERR: 1), locked stays 1, next words match (flywheel).
- Locked; corrupt 3 consecutive words -> err pulses 3 times, sync_lost pulse with locked→0 on the 3rd; clean stream relocks after 5 more words.
- HUNT fed 8'h00 (INVERT=0) repeatedly -> stays HUNT; VERIFY fed a break after 2 matches -> reseeds, locked only after 4 further matches.
- CNT_W=4, 20 single-word errors with lock held -> err_count sticks at 15; clear coincident with an error -> err_count=1 (BITERR, 3 flipped bits: 3).
- valid toggled 50% randomly, then reset asserted while LOCKED -> no false errors during gaps; after reset all outputs 0, state HUNT.
